// File: rtl/data_sram_axi_bridge.sv
// Responder for the memory stage's data_sram port: one AXI4-Lite-style read or write per request, minimum 4-cycle latency.
// Backpressure: data_stall holds the pipeline until the bus handshakes finish; valids are held until accepted.
module data_sram_axi_bridge #(
    parameter int ADDR_MAP_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_stall,
    output logic        bus_err,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]  state;
    logic        aw_done;
    logic        w_done;
    logic        aw_hs;
    logic        w_hs;
    logic [31:0] paddr;
    logic [2:0]  awsize_nxt;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    // kseg0/kseg1 are unmapped windows onto the low 512 MB of physical space
    always_comb begin
        paddr = data_sram_addr;
        if ((ADDR_MAP_EN != 0) &&
            ((data_sram_addr[31:29] == 3'b100) || (data_sram_addr[31:29] == 3'b101))) begin
            paddr = {3'b000, data_sram_addr[28:0]};
        end
    end

    always_comb begin
        awsize_nxt = 3'd2;
        case (data_sram_wen)
            4'b0011, 4'b1100:                   awsize_nxt = 3'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: awsize_nxt = 3'd0;
            default:                            awsize_nxt = 3'd2;
        endcase
    end

    always_comb begin
        data_stall = 1'b0;
        case (state)
            RD_ADDR, RD_DATA, WR_REQ, WR_RESP: data_stall = 1'b1;
            IDLE:                              data_stall = data_sram_en;
            default:                           data_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            data_sram_rdata <= 32'd0;
            bus_err         <= 1'b0;
            araddr          <= 32'd0;
            arsize          <= 3'd0;
            arvalid         <= 1'b0;
            rready          <= 1'b0;
            awaddr          <= 32'd0;
            awsize          <= 3'd0;
            awvalid         <= 1'b0;
            wdata           <= 32'd0;
            wstrb           <= 4'd0;
            wvalid          <= 1'b0;
            bready          <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_sram_en) begin
                        if (data_sram_wen == 4'b0000) begin
                            araddr  <= {paddr[31:2], 2'b00};
                            arsize  <= 3'd2;
                            arvalid <= 1'b1;
                            state   <= RD_ADDR;
                        end else begin
                            awaddr  <= paddr;
                            awsize  <= awsize_nxt;
                            wdata   <= data_sram_wdata;
                            wstrb   <= data_sram_wen;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= WR_REQ;
                        end
                    end
                end
                RD_ADDR: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid && rready) begin
                        data_sram_rdata <= rdata;
                        bus_err         <= (rresp != 2'b00);
                        rready          <= 1'b0;
                        state           <= DONE;
                    end
                end
                WR_REQ: begin
                    // AW and W channels retire independently, in any order
                    if (aw_hs) awvalid <= 1'b0;
                    if (w_hs)  wvalid  <= 1'b0;
                    aw_done <= aw_done | aw_hs;
                    w_done  <= w_done | w_hs;
                    if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid && bready) begin
                        bus_err <= (bresp != 2'b00);
                        bready  <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Directed bench for data_sram_axi_bridge: inputs driven and outputs sampled on the falling edge.
module tb_data_sram_axi_bridge;

    logic        clk;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_stall;
    logic        bus_err;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks;
    int failures;

    data_sram_axi_bridge #(.ADDR_MAP_EN(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .data_stall      (data_stall),
        .bus_err         (bus_err),
        .araddr          (araddr),
        .arsize          (arsize),
        .arvalid         (arvalid),
        .arready         (arready),
        .rdata           (rdata),
        .rresp           (rresp),
        .rvalid          (rvalid),
        .rready          (rready),
        .awaddr          (awaddr),
        .awsize          (awsize),
        .awvalid         (awvalid),
        .awready         (awready),
        .wdata           (wdata),
        .wstrb           (wstrb),
        .wvalid          (wvalid),
        .wready          (wready),
        .bresp           (bresp),
        .bvalid          (bvalid),
        .bready          (bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        data_sram_en = 1'b0; data_sram_wen = 4'd0;
        data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
        arready = 1'b0; rdata = 32'd0; rresp = 2'd0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'd0; bvalid = 1'b0;

        // reset state
        tick();
        chk1("rst_arvalid", arvalid, 1'b0);
        chk1("rst_rready", rready, 1'b0);
        chk1("rst_awvalid", awvalid, 1'b0);
        chk1("rst_wvalid", wvalid, 1'b0);
        chk1("rst_bready", bready, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk1("rst_stall", data_stall, 1'b0);
        chk32("rst_rdata", data_sram_rdata, 32'h0);
        chk32("rst_araddr", araddr, 32'h0);
        rst = 1'b0;
        tick();
        chk1("idle_no_ar", arvalid, 1'b0);

        // read, zero-wait slave, kseg0 address
        data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h8000_1004;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        #1 chk1("rd_stall_idle", data_stall, 1'b1);
        tick();
        chk32("rd_araddr", araddr, 32'h0000_1004);
        chk32("rd_arsize", 32'(arsize), 32'd2);
        chk1("rd_arvalid", arvalid, 1'b1);
        chk1("rd_stall_addr", data_stall, 1'b1);
        tick();
        chk1("rd_arvalid_drop", arvalid, 1'b0);
        chk1("rd_rready", rready, 1'b1);
        chk1("rd_stall_data", data_stall, 1'b1);
        tick();
        chk32("rd_rdata", data_sram_rdata, 32'hDEAD_BEEF);
        chk1("rd_stall_done", data_stall, 1'b0);
        chk1("rd_rready_drop", rready, 1'b0);
        chk1("rd_bus_err", bus_err, 1'b0);
        tick();
        chk1("rd_no_second_ar", arvalid, 1'b0);
        data_sram_en = 1'b0; arready = 1'b0; rvalid = 1'b0;
        tick();
        chk1("rd_idle_quiet", arvalid, 1'b0);
        chk1("rd_idle_stall", data_stall, 1'b0);

        // kseg1 store-byte
        data_sram_en = 1'b1; data_sram_wen = 4'b1000; data_sram_addr = 32'hBFC0_0003;
        data_sram_wdata = 32'h5A5A_5A5A;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        tick();
        chk32("sb_awaddr", awaddr, 32'h1FC0_0003);
        chk32("sb_awsize", 32'(awsize), 32'd0);
        chk32("sb_wstrb", 32'(wstrb), 32'h8);
        chk32("sb_wdata", wdata, 32'h5A5A_5A5A);
        chk1("sb_awvalid", awvalid, 1'b1);
        chk1("sb_wvalid", wvalid, 1'b1);
        chk1("sb_bready_early", bready, 1'b0);
        tick();
        chk1("sb_bready", bready, 1'b1);
        chk1("sb_awvalid_drop", awvalid, 1'b0);
        chk1("sb_wvalid_drop", wvalid, 1'b0);
        tick();
        chk1("sb_stall_done", data_stall, 1'b0);
        chk1("sb_bready_drop", bready, 1'b0);
        chk32("sb_rdata_kept", data_sram_rdata, 32'hDEAD_BEEF);
        tick();
        chk1("sb_no_second_aw", awvalid, 1'b0);
        data_sram_en = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        tick();

        // AW/W skew: awready arrives 3 cycles after wready
        data_sram_en = 1'b1; data_sram_wen = 4'b1111; data_sram_addr = 32'h0000_2000;
        data_sram_wdata = 32'hCAFE_F00D;
        wready = 1'b1;
        tick();
        chk32("sk_awaddr", awaddr, 32'h0000_2000);
        chk32("sk_awsize", 32'(awsize), 32'd2);
        chk1("sk_both_valid", awvalid & wvalid, 1'b1);
        tick();
        chk1("sk_wvalid_drop", wvalid, 1'b0);
        chk1("sk_awvalid_hold1", awvalid, 1'b1);
        chk1("sk_bready_wait1", bready, 1'b0);
        wready = 1'b0;
        tick();
        chk1("sk_awvalid_hold2", awvalid, 1'b1);
        chk1("sk_bready_wait2", bready, 1'b0);
        chk1("sk_wvalid_stay", wvalid, 1'b0);
        tick();
        awready = 1'b1;
        tick();
        chk1("sk_awvalid_drop", awvalid, 1'b0);
        chk1("sk_bready", bready, 1'b1);
        awready = 1'b0;
        tick();
        chk1("sk_bready_hold", bready, 1'b1);
        chk1("sk_stall_resp", data_stall, 1'b1);
        bvalid = 1'b1;
        tick();
        chk1("sk_bready_drop", bready, 1'b0);
        chk1("sk_stall_done", data_stall, 1'b0);
        tick();
        data_sram_en = 1'b0;
        tick();
        chk1("sk_one_b", bready, 1'b0);
        bvalid = 1'b0;

        // read error; kseg2 address passes through unmapped
        data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'hC000_0042;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b10;
        tick();
        chk32("re_araddr", araddr, 32'hC000_0040);
        chk1("re_err_early", bus_err, 1'b0);
        tick();
        tick();
        chk1("re_bus_err", bus_err, 1'b1);
        chk32("re_rdata", data_sram_rdata, 32'h1234_5678);
        tick();
        chk1("re_bus_err_clear", bus_err, 1'b0);
        data_sram_en = 1'b0; arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
        tick();

        // back-to-back store then load, en held, rvalid delayed 2 cycles
        data_sram_en = 1'b1; data_sram_wen = 4'b0011; data_sram_addr = 32'h0000_0100;
        data_sram_wdata = 32'h1111_2222;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        tick();
        chk32("bb_awsize", 32'(awsize), 32'd1);
        chk1("bb_stall_wreq", data_stall, 1'b1);
        tick();
        chk1("bb_stall_wresp", data_stall, 1'b1);
        tick();
        chk1("bb_stall_wdone", data_stall, 1'b0);
        data_sram_wen = 4'b0000; data_sram_addr = 32'h8000_0200;
        bvalid = 1'b0; awready = 1'b0; wready = 1'b0; arready = 1'b1; rvalid = 1'b0;
        tick();
        chk1("bb_no_dup_aw", awvalid, 1'b0);
        chk1("bb_no_dup_w", wvalid, 1'b0);
        chk1("bb_stall_idle", data_stall, 1'b1);
        tick();
        chk1("bb_arvalid", arvalid, 1'b1);
        chk32("bb_araddr", araddr, 32'h0000_0200);
        tick();
        chk1("bb_rready1", rready, 1'b1);
        chk1("bb_stall_r1", data_stall, 1'b1);
        tick();
        chk1("bb_rready2", rready, 1'b1);
        chk1("bb_stall_r2", data_stall, 1'b1);
        rvalid = 1'b1; rdata = 32'hA5A5_0F0F;
        tick();
        chk32("bb_rdata", data_sram_rdata, 32'hA5A5_0F0F);
        chk1("bb_stall_rdone", data_stall, 1'b0);
        data_sram_en = 1'b0; rvalid = 1'b0; arready = 1'b0;
        tick();
        chk1("bb_no_dup_ar", arvalid, 1'b0);
        chk1("bb_idle_no_aw", awvalid, 1'b0);

        // reset while in RD_DATA
        data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h0000_0300;
        arready = 1'b1; rvalid = 1'b0;
        tick();
        tick();
        chk1("rr_rready_pre", rready, 1'b1);
        rst = 1'b1;
        tick();
        chk1("rr_rready", rready, 1'b0);
        chk1("rr_arvalid", arvalid, 1'b0);
        chk32("rr_rdata", data_sram_rdata, 32'h0);
        chk1("rr_stall_en1", data_stall, 1'b1);
        rst = 1'b0; data_sram_en = 1'b0;
        #1 chk1("rr_stall_en0", data_stall, 1'b0);
        tick();
        chk1("rr_idle_quiet", arvalid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_sram_axi_bridge.md
Name: data_sram_axi_bridge

Overview:
- Responder end of the data_sram interface that the memory-access stage drives.
- Accepts one load or store per request from the pipeline, translates the virtual address to a physical one, and runs a single AXI4-Lite-style transaction on the system bus.
- Returns the read word and holds the pipeline with a stall signal until the transaction completes.
- Sits between the memory-access stage and the SoC bus interconnect.

Parameters:
- ADDR_MAP_EN, 1, when 1 map kseg0/kseg1 (addr[31:29] = 3'b100 or 3'b101) to {3'b000, addr[28:0]}; when 0 pass the address through unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- data_sram_en  in  1  request valid, held stable by the pipeline while data_stall=1
- data_sram_wen  in  4  byte write enables; 0000 means read
- data_sram_addr  in  32  virtual byte address
- data_sram_wdata  in  32  store data, already lane-replicated
- data_sram_rdata  out  32  returned read word, full 32 bits; the pipeline extracts lanes
- data_stall  out  1  pipeline hold
- bus_err  out  1  one-cycle pulse when rresp or bresp is nonzero
- araddr  out  32  read address; arsize out 3; arvalid out 1; arready in 1
- rdata  in  32  read data; rresp in 2; rvalid in 1; rready out 1
- awaddr  out  32  write address; awsize out 3; awvalid out 1; awready in 1
- wdata  out  32  write data; wstrb out 4; wvalid out 1; wready in 1
- bresp  in  2  write response; bvalid in 1; bready out 1

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- Reset values: state=IDLE; all valid/ready outputs 0; data_sram_rdata=0; bus_err=0; address/size/data/strobe registers 0.
- IDLE with en=1 and wen=0000:
  - Latch araddr={paddr[31:2],2'b00}, arsize=3'd2.
  - arvalid=1 from the next cycle; go to RD_ADDR.
- IDLE with en=1 and wen!=0000:
  - Latch awaddr=paddr, wdata, wstrb=wen.
  - awsize: 2 for 1111, 1 for 0011 or 1100, 0 for any single-bit strobe.
  - awvalid=1 and wvalid=1 from the next cycle; go to WR_REQ.
- RD_ADDR: on arvalid&&arready, drop arvalid, set rready=1, go to RD_DATA.
- RD_DATA: on rvalid&&rready:
  - data_sram_rdata<=rdata.
  - bus_err<=(rresp!=0).
  - Drop rready, go to DONE.
- WR_REQ:
  - awvalid and wvalid drop independently on their own handshakes; AW and W may complete in the same cycle or in either order.
  - Once both have completed (tracked by two done flags), set bready=1 and go to WR_RESP.
- WR_RESP: on bvalid&&bready, bus_err<=(bresp!=0), drop bready, go to DONE.
- DONE: one cycle; go to IDLE unconditionally. The request still on the inputs this cycle is the completed one and must not be re-accepted.
- data_stall, combinational:
  - 1 when state in {RD_ADDR, RD_DATA, WR_REQ, WR_RESP}.
  - 1 when state==IDLE and en=1.
  - 0 in DONE and when IDLE with en=0.
- Minimum request latency: 4 cycles (IDLE, RD_ADDR, RD_DATA, DONE) with arready and rvalid both 1 in their first cycles.
- data_sram_rdata holds its value until the next read completes; writes do not change it.
- bus_err is high only in the DONE cycle; it is cleared on every other cycle.
- Valid signals are never withdrawn before their handshake, except on rst.
- rst mid-transaction: return to IDLE with all valid/ready outputs dropped on the next edge; the bus slave is reset by the same rst.
- en=0 in IDLE: no bus activity, all valids stay 0.

Test Plan:
- Read, zero-wait slave: en=1, wen=0, addr=0x8000_1004, slave returns rdata=0xDEAD_BEEF.
  - Required: araddr=0x0000_1004, arsize=2, stall high for 3 cycles, rdata=0xDEAD_BEEF in DONE, stall=0 in DONE, no second AR.
- kseg1 store-byte: addr=0xBFC0_0003, wen=1000, wdata=0x5A5A_5A5A.
  - Required: awaddr=0x1FC0_0003, awsize=0, wstrb=1000, wdata=0x5A5A_5A5A.
- AW/W skew: awready asserted 3 cycles after wready.
  - Required: wvalid drops first, awvalid holds until its handshake, bready rises only after both complete, exactly one B accepted.
- Read error: rresp=2'b10 with rdata=0x1234_5678.
  - Required: bus_err=1 for exactly the DONE cycle, rdata=0x1234_5678.
- Back-to-back: store then load with en held, slave inserts 2-cycle rvalid delay.
  - Required: one AW/W/B, then one AR/R, no duplicate transaction, stall low only in each DONE cycle.
- Reset in RD_DATA: assert rst for 1 cycle.
  - Required: next cycle state IDLE, rready=0, arvalid=0, data_sram_rdata=0, data_stall follows en.
